rx_bit_sampler: RTL and testbench

Receive-side front end of the UART. It synchronises the raw serial line, oversamples each bit at PRESCALE clocks per bit, takes a 3-sample majority vote at mid-bit and rejects false start bits. It delivers one voted bit per bit period on SER_DATA, qualified by a one-cycle RX_tick. These outputs feed the RX control FSM and its deserialiser, parity and stop checkers.

---
 rtl/rx_bit_sampler.sv | 141 ++++++++++++++
 tb/tb_rx_bit_sampler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_sampler.sv
// UART receive front end: synchronises RX_IN, oversamples each bit at
// PRESCALE clocks per bit, takes a 3-sample majority vote around mid-bit,
// rejects false start bits and delivers one voted bit per bit period.
module rx_bit_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  ENABLE,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    output logic                  SER_DATA,
    output logic                  RX_tick,
    output logic                  START_GLITCH,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_BITS + 4);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic [PRESCALE_W-1:0]  pres_l;
    logic [PRESCALE_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]       frame_l;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   s0, s1, s2;

    logic [PRESCALE_W-1:0]  mid, mid_m1, mid_p1, mid_p2, last;
    logic                   at_m1, at_mid, at_p1, at_p2, at_last;
    logic                   s2_eff, vote, start_ok, glitch_now, last_bit;

    assign rx_s = sync[SYNC_STAGES-1];

    // Sample positions within the bit, all relative to the latched prescale
    always_comb begin
        mid     = pres_l >> 1;
        mid_m1  = mid - PRESCALE_W'(1);
        mid_p1  = mid + PRESCALE_W'(1);
        mid_p2  = mid + PRESCALE_W'(2);
        last    = pres_l - PRESCALE_W'(1);
        at_m1   = (edge_cnt == mid_m1);
        at_mid  = (edge_cnt == mid);
        at_p1   = (edge_cnt == mid_p1);
        at_p2   = (edge_cnt == mid_p2);
        at_last = (edge_cnt == last);
        // With PRESCALE=4 the third sample lands on the tick cycle itself,
        // so take it straight from the line instead of the register.
        s2_eff  = at_p1 ? rx_s : s2;
        vote    = (s0 & s1) | (s0 & s2_eff) | (s1 & s2_eff);
        start_ok = ENABLE && (PRESCALE >= PRESCALE_W'(4)) && rx_prev && !rx_s;
        // Start check runs the cycle after the last sample; for very short
        // bits that coincides with (or folds into) the tick cycle.
        glitch_now = (bit_cnt == '0) && vote && (at_p2 || at_last);
        last_bit   = (bit_cnt == frame_l - CNT_W'(1));
    end

    // Two-or-more flop synchroniser for the asynchronous serial line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], RX_IN};
        end
    end

    // Frame sequencer: start detection, bit timing, voting and delivery
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            rx_prev      <= 1'b1;
            pres_l       <= '0;
            frame_l      <= '0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            s2           <= 1'b1;
            SER_DATA     <= 1'b1;
            RX_tick      <= 1'b0;
            START_GLITCH <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            RX_tick      <= 1'b0;
            START_GLITCH <= 1'b0;
            rx_prev      <= rx_s;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pres_l   <= PRESCALE;
                        frame_l  <= CNT_W'(DATA_BITS + 2) + CNT_W'(PAR_EN);
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= RUN;
                        BUSY     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!ENABLE) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        SER_DATA <= 1'b1;
                    end else if (glitch_now) begin
                        state        <= IDLE;
                        BUSY         <= 1'b0;
                        START_GLITCH <= 1'b1;
                    end else begin
                        if (at_m1)  s0 <= rx_s;
                        if (at_mid) s1 <= rx_s;
                        if (at_p1)  s2 <= rx_s;
                        if (at_last) begin
                            SER_DATA <= vote;
                            RX_tick  <= 1'b1;
                            edge_cnt <= '0;
                            if (last_bit) begin
                                state   <= IDLE;
                                BUSY    <= 1'b0;
                                // The next start bit may already be on the line
                                // here; seed the edge detector with the voted
                                // stop level so that start is still seen as a fall.
                                rx_prev <= vote;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else begin
                            edge_cnt <= edge_cnt + PRESCALE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: drives serial frames, queues the expected voted
// bits and compares them against SER_DATA at each RX_tick.
module tb_rx_bit_sampler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       ENABLE;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       SER_DATA;
    logic       RX_tick;
    logic       START_GLITCH;
    logic       BUSY;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   glitch_cnt = 0;
    int   glitch_cyc = 0;
    int   g0;
    int   c0;
    logic exp_q[$];
    int   tick_cyc[$];

    rx_bit_sampler #(
        .PRESCALE_W (6),
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .ENABLE      (ENABLE),
        .PRESCALE    (PRESCALE),
        .PAR_EN      (PAR_EN),
        .SER_DATA    (SER_DATA),
        .RX_tick     (RX_tick),
        .START_GLITCH(START_GLITCH),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every tick pops one expected bit
    always @(negedge CLK) begin
        if (RST === 1'b1 && RX_tick === 1'b1) begin
            tick_cyc.push_back(cyc);
            if (exp_q.size() == 0) check_val("tick_unexpected", 32'(RX_tick), 32'(0));
            else check_val("ser_data", 32'(SER_DATA), 32'(exp_q.pop_front()));
        end
        if (START_GLITCH === 1'b1) begin
            glitch_cnt <= glitch_cnt + 1;
            glitch_cyc <= cyc;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive one frame on RX_IN; push the first n_push expected bits.
    // spike_bit >= 0 inverts that bit for one cycle at its mid sample.
    task automatic send_frame(input logic [7:0] data, input int pres, input logic par_en,
                              input int n_push, input int spike_bit);
        logic [10:0] b;
        int nb;
        b[0]   = 1'b0;
        b[8:1] = data;
        b[9]   = par_en ? ^data : 1'b1;
        b[10]  = 1'b1;
        nb     = par_en ? 11 : 10;
        PAR_EN = par_en;
        for (int i = 0; i < nb; i++)
            if (i < n_push) exp_q.push_back(b[i]);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < pres; c++) begin
                RX_IN = (i == spike_bit && c == pres / 2 + 1) ? ~b[i] : b[i];
                @(posedge CLK);
                #1;
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic wait_ticks(input int n, input int limit);
        int k;
        k = 0;
        while (tick_cyc.size() < n && k < limit) begin
            @(negedge CLK);
            #1;
            k++;
        end
        if (tick_cyc.size() < n) check_val("tick_wait_timeout", 32'(tick_cyc.size()), 32'(n));
    endtask

    task automatic check_gaps(input int gap, input int skip);
        for (int i = 1; i < tick_cyc.size(); i++)
            if (i != skip) check_val("tick_gap", 32'(tick_cyc[i] - tick_cyc[i-1]), 32'(gap));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; RX_IN = 1'b1; ENABLE = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_ser_data", 32'(SER_DATA), 32'(1));
        check_val("rst_rx_tick", 32'(RX_tick), 32'(0));
        check_val("rst_glitch", 32'(START_GLITCH), 32'(0));
        check_val("rst_busy", 32'(BUSY), 32'(0));
        RST = 1'b1;
        idle_cycles(5);

        // 0xA5 with even parity at 8 clocks per bit
        tick_cyc.delete(); g0 = glitch_cnt;
        fork
            send_frame(8'hA5, 8, 1'b1, 11, -1);
            begin
                wait_ticks(1, 100);
                check_val("busy_in_frame", 32'(BUSY), 32'(1));
            end
        join
        idle_cycles(20);
        check_val("par_ticks", 32'(tick_cyc.size()), 32'(11));
        check_gaps(8, -1);
        check_val("par_q_empty", 32'(exp_q.size()), 32'(0));
        check_val("par_no_glitch", 32'(glitch_cnt - g0), 32'(0));
        check_val("par_busy_end", 32'(BUSY), 32'(0));

        // False start: line low for 3 cycles only
        PRESCALE = 6'd16; tick_cyc.delete(); g0 = glitch_cnt; c0 = cyc;
        RX_IN = 1'b0;
        idle_cycles(3);
        RX_IN = 1'b1;
        idle_cycles(40);
        check_val("fs_glitch_cnt", 32'(glitch_cnt - g0), 32'(1));
        check_val("fs_glitch_when", 32'(glitch_cyc - c0 >= 11 && glitch_cyc - c0 <= 15), 32'(1));
        check_val("fs_ticks", 32'(tick_cyc.size()), 32'(0));
        check_val("fs_ser_data", 32'(SER_DATA), 32'(1));
        check_val("fs_busy", 32'(BUSY), 32'(0));

        // Noise spike on bit 2 of 0x0F at its mid sample
        tick_cyc.delete();
        send_frame(8'h0F, 16, 1'b0, 10, 3);
        idle_cycles(40);
        check_val("noise_ticks", 32'(tick_cyc.size()), 32'(10));
        check_gaps(16, -1);
        check_val("noise_q_empty", 32'(exp_q.size()), 32'(0));

        // Back-to-back 0x00 then 0xFF
        tick_cyc.delete();
        send_frame(8'h00, 16, 1'b0, 10, -1);
        send_frame(8'hFF, 16, 1'b0, 10, -1);
        idle_cycles(40);
        check_val("b2b_ticks", 32'(tick_cyc.size()), 32'(20));
        check_gaps(16, 10);
        check_val("b2b_q_empty", 32'(exp_q.size()), 32'(0));

        // Abort by ENABLE after the 4th tick
        PRESCALE = 6'd8; tick_cyc.delete();
        fork
            send_frame(8'hC3, 8, 1'b0, 4, -1);
            begin
                wait_ticks(4, 200);
                ENABLE = 1'b0;
                @(negedge CLK);
                #1;
                check_val("abort_busy", 32'(BUSY), 32'(0));
                check_val("abort_ser", 32'(SER_DATA), 32'(1));
                check_val("abort_tick", 32'(RX_tick), 32'(0));
            end
        join
        idle_cycles(20);
        ENABLE = 1'b1;
        idle_cycles(5);
        check_val("abort_ticks", 32'(tick_cyc.size()), 32'(4));
        check_val("abort_q_empty", 32'(exp_q.size()), 32'(0));

        // Abort by reset after the 4th tick
        tick_cyc.delete();
        fork
            send_frame(8'hFB, 8, 1'b0, 4, -1);
            begin
                wait_ticks(4, 200);
                RST = 1'b0;
                #1;
                check_val("rstab_ser", 32'(SER_DATA), 32'(1));
                check_val("rstab_tick", 32'(RX_tick), 32'(0));
                check_val("rstab_busy", 32'(BUSY), 32'(0));
                @(negedge CLK);
                RST = 1'b1;
            end
        join
        idle_cycles(20);
        check_val("rstab_ticks", 32'(tick_cyc.size()), 32'(4));
        check_val("rstab_q_empty", 32'(exp_q.size()), 32'(0));

        // Clean frame after the aborts
        tick_cyc.delete();
        send_frame(8'h3C, 8, 1'b0, 10, -1);
        idle_cycles(20);
        check_val("post_ticks", 32'(tick_cyc.size()), 32'(10));
        check_gaps(8, -1);
        check_val("post_q_empty", 32'(exp_q.size()), 32'(0));

        // PRESCALE changed mid-frame is ignored
        tick_cyc.delete();
        fork
            send_frame(8'h55, 8, 1'b0, 10, -1);
            begin
                idle_cycles(20);
                PRESCALE = 6'd16;
            end
        join
        idle_cycles(20);
        check_val("pchg_ticks", 32'(tick_cyc.size()), 32'(10));
        check_gaps(8, -1);
        tick_cyc.delete();
        send_frame(8'h96, 16, 1'b0, 10, -1);
        idle_cycles(40);
        check_val("pchg2_ticks", 32'(tick_cyc.size()), 32'(10));
        check_gaps(16, -1);
        check_val("pchg_q_empty", 32'(exp_q.size()), 32'(0));

        // PRESCALE below 4 never starts
        PRESCALE = 6'd3; tick_cyc.delete();
        send_frame(8'h00, 3, 1'b0, 0, -1);
        idle_cycles(20);
        check_val("lowpres_ticks", 32'(tick_cyc.size()), 32'(0));
        check_val("lowpres_busy", 32'(BUSY), 32'(0));

        // ENABLE low never starts
        PRESCALE = 6'd8; ENABLE = 1'b0; tick_cyc.delete();
        send_frame(8'h00, 8, 1'b0, 0, -1);
        idle_cycles(20);
        check_val("dis_ticks", 32'(tick_cyc.size()), 32'(0));
        check_val("dis_busy", 32'(BUSY), 32'(0));
        ENABLE = 1'b1;
        idle_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
